// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider: one shift/subtract pair per quotient bit, Done after 2*WIDTH+1 edges (1 edge for divide-by-zero).
// No backpressure: Run is a level start, operands are sampled once, and DONE holds until Run drops.
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Done,
    output logic             Busy,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // r is one bit wider than the operands so the shifted partial remainder never overflows
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic             sub_ok;
    logic [WIDTH:0]   r_sub;
    logic [WIDTH-1:0] q_sub;

    assign sub_ok = (r >= {1'b0, d});
    assign r_sub  = sub_ok ? (r - {1'b0, d}) : r;
    assign q_sub  = {q[WIDTH-1:1], sub_ok};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Done      = 1'b0;
        Busy      = 1'b0;
        case (state)
            IDLE: begin
                if (Run) begin
                    state_nxt = (Divisor == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                Busy      = 1'b1;
                state_nxt = SUB;
            end
            SUB: begin
                Busy      = 1'b1;
                state_nxt = (count == CW'(1)) ? DONE : SHIFT;
            end
            DONE: begin
                Done = 1'b1;
                if (!Run) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        d       <= Divisor;
                        q       <= Dividend;
                        r       <= '0;
                        count   <= CW'(WIDTH);
                        DivZero <= 1'b0;
                        if (Divisor == '0) begin
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivZero   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r <= {r[WIDTH-1:0], q[WIDTH-1]};
                    q <= {q[WIDTH-2:0], 1'b0};
                end
                SUB: begin
                    r     <= r_sub;
                    q     <= q_sub;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        Quotient  <= q_sub;
                        Remainder <= r_sub[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
